// File: rtl/pipe_share_scheduler_if.sv
// pipe_share_scheduler_if: requester, datapath and result signals of the shared-pipeline scheduler.
interface pipe_share_scheduler_if #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_DEPTH  = 8
);
  logic                               req0_valid;
  logic [DATA_WIDTH-1:0]              req0_data;
  logic                               req0_ready;
  logic                               req1_valid;
  logic [DATA_WIDTH-1:0]              req1_data;
  logic                               req1_ready;
  logic                               pipe_in_valid;
  logic [DATA_WIDTH-1:0]              pipe_in_data;
  logic [DATA_WIDTH-1:0]              pipe_out_data;
  logic                               res_valid;
  logic [DATA_WIDTH-1:0]              res_data;
  logic                               res_id;
  logic                               res_ready;
  logic [$clog2(OUT_DEPTH+1)-1:0]     inflight_count;
  logic                               idle;
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, pipe_out_data, res_ready,
    input  req0_ready, req1_ready, pipe_in_valid, pipe_in_data, res_valid, res_data, res_id,
           inflight_count, idle
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, pipe_out_data, res_ready,
    output req0_ready, req1_ready, pipe_in_valid, pipe_in_data, res_valid, res_data, res_id,
           inflight_count, idle
  );
endinterface

// File: rtl/pipe_share_scheduler.sv
// pipe_share_scheduler: round-robin sharing of a fixed-latency pipeline with credit-protected result FIFO.
module pipe_share_scheduler #(
  parameter int LATENCY    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_DEPTH  = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  pipe_share_scheduler_if.slave bus
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH+1);
  logic [LATENCY-1:0]    tag_v_q, tag_id_q;
  logic [LATENCY:0]      tag_v_d, tag_id_d;
  logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
  logic [OUT_DEPTH-1:0]  id_mem_q;
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q, cnt_d, inflight_q, inflight_d;
  logic                  prio_q, prio_d;
  logic                  credit_ok, g0, g1, issue, cap, pop;
  // Credits come only from registered state, so a pop frees a slot one cycle later.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, cnt_q}) < (CW+1)'(OUT_DEPTH);
  assign g0        = bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign g1        = bus.req1_valid & (~bus.req0_valid | prio_q);
  assign issue     = (g0 | g1) & credit_ok;
  assign cap       = tag_v_q[LATENCY-1];
  assign pop       = (cnt_q != '0) & bus.res_ready;
  assign tag_v_d   = {tag_v_q, issue};
  assign tag_id_d  = {tag_id_q, g1};
  assign inflight_d = inflight_q + CW'(issue) - CW'(cap);
  assign cnt_d      = cnt_q + CW'(cap) - CW'(pop);
  assign prio_d     = issue ? g0 : prio_q;
  assign bus.req0_ready     = g0 & credit_ok;
  assign bus.req1_ready     = g1 & credit_ok;
  assign bus.pipe_in_valid  = issue;
  assign bus.pipe_in_data   = g1 ? bus.req1_data : bus.req0_data;
  assign bus.res_valid      = cnt_q != '0;
  assign bus.res_data       = mem_q[rd_q];
  assign bus.res_id         = id_mem_q[rd_q];
  assign bus.inflight_count = inflight_q;
  assign bus.idle           = (inflight_q == '0) & (cnt_q == '0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      inflight_q <= '0;
      prio_q     <= 1'b0;
    end else begin
      tag_v_q    <= tag_v_d[LATENCY-1:0];
      tag_id_q   <= tag_id_d[LATENCY-1:0];
      wr_q       <= cap ? wr_q + AW'(1) : wr_q;
      rd_q       <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      prio_q     <= prio_d;
    end
  end
  always_ff @(posedge clk) begin
    if (cap) begin
      mem_q[wr_q]    <= bus.pipe_out_data;
      id_mem_q[wr_q] <= tag_id_q[LATENCY-1];
    end
  end
endmodule

// File: doc/pipe_share_scheduler.md
Name: pipe_share_scheduler

Overview:
- Shares one fixed-latency, non-stallable datapath pipeline between two requesters. The pipeline is a chain of delay registers plus arithmetic, LATENCY cycles deep.
- Round-robin arbitrates issue slots and tracks a valid/ID tag alongside each in-flight operation.
- Captures pipeline results into a result FIFO with a valid/ready output.
- Credit accounting guarantees results are never dropped, because the pipeline itself cannot be stalled.

Parameters:
- LATENCY, 4: cycles from pipe_in_valid/pipe_in_data to matching pipe_out_data; >= 1.
- DATA_WIDTH, 64: operand/result width.
- OUT_DEPTH, 8: result FIFO entries; power of two, >= 2; also the total credit count.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand.
- req0_data  in  DATA_WIDTH  requester 0 operand.
- req0_ready  out  1  requester 0 operand accepted this cycle.
- req1_valid  in  1  requester 1 has an operand.
- req1_data  in  DATA_WIDTH  requester 1 operand.
- req1_ready  out  1  requester 1 operand accepted this cycle.
- pipe_in_valid  out  1  operand issued to the datapath this cycle.
- pipe_in_data  out  DATA_WIDTH  issued operand.
- pipe_out_data  in  DATA_WIDTH  datapath result, LATENCY cycles after issue.
- res_valid  out  1  result FIFO non-empty.
- res_data  out  DATA_WIDTH  head result.
- res_id  out  1  requester ID of head result.
- res_ready  in  1  consumer pops the head when res_valid is high.
- inflight_count  out  $clog2(OUT_DEPTH+1)  operations issued but not yet captured.
- idle  out  1  inflight_count==0 and FIFO empty.

Behaviour:
- Reset (rst_n=0 at posedge) clears:
  - tag shift register (LATENCY entries of {valid,id}), FIFO pointers/occupancy, inflight_count;
  - priority pointer set to requester 0.
- Reset outputs: res_valid=0, pipe_in_valid=0, req*_ready=0, inflight_count=0, idle=1.
- Reset mid-operation discards all in-flight tags. pipe_out_data arriving later is ignored and never reaches the FIFO.
- Credit check: issue is allowed iff (registered inflight_count + registered FIFO occupancy) < OUT_DEPTH.
  - A pop in the same cycle does not free a credit until the next cycle.
  - There is no combinational path from res_ready to req*_ready.
- Arbitration (combinational on registered state):
  - Only one valid requester: that one is granted.
  - Both valid: the one the priority pointer favours is granted.
  - reqN_ready = grantN & credit_ok. Handshake completes when reqN_valid & reqN_ready.
- On issue:
  - pipe_in_valid=1 and pipe_in_data = granted data, both combinational in the same cycle.
  - tag {1,id} enters the tag shift register; inflight_count increments.
  - Priority pointer moves to the non-granted requester. The pointer is unchanged when nothing issues.
- Capture: when the tag shift register output is valid (exactly LATENCY cycles after issue):
  - pipe_out_data and the id are written to the FIFO at that posedge;
  - inflight_count decrements.
- Simultaneous issue and capture leave inflight_count unchanged.
- Timing: first res_valid for an op issued at cycle t appears at cycle t+LATENCY+1, giving a total latency of LATENCY+1.
- FIFO behaviour:
  - res_data/res_id reflect the head entry.
  - Pop on res_valid & res_ready.
  - Simultaneous push and pop is legal at any occupancy, including full-minus-in-flight.
  - Pointers wrap modulo OUT_DEPTH.
- Overflow is structurally impossible under the credit rule; a push into a full FIFO is a bench assertion failure.
- Results leave the FIFO in issue order.
- Back-to-back issue is sustained at 1 op/cycle while credits remain.

Test Plan:
- Single op (LATENCY=4, OUT_DEPTH=8): req0_valid with data 0x11 at cycle 0, bench pipeline returns data+1.
  - Required: pipe_in_valid at cycle 0.
  - Required: res_valid at cycle 5 with res_data 0x12, res_id 0.
  - Required: idle=1 after the pop.
- Contention: both requesters valid continuously, res_ready=1.
  - Required: grants alternate 0,1,0,1,... starting with 0 after reset.
  - Required: res_id sequence matches, throughput 1/cycle.
- Backpressure (OUT_DEPTH=4): both valid, res_ready=0.
  - Required: exactly 4 issues, then req*_ready=0.
  - Required: after all 4 results are captured, inflight_count=0 and occupancy 4.
  - Required: one pop gives exactly one new issue, on the following cycle.
- Same-cycle events: FIFO holding 3, one capture, one pop and one new issue all in the same cycle.
  - Required: occupancy stays 3 and inflight_count is unchanged.
  - Required: data order is preserved across pointer wrap.
- Reset mid-flight: issue 3 ops, assert rst_n=0 for 1 cycle 2 cycles later.
  - Required: no res_valid ever for those ops, inflight_count=0, idle=1, priority back to requester 0.
- Single requester: only req1 valid for 10 cycles.
  - Required: granted every cycle, 10 results with res_id 1, in order.
